// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  // Transmitter FSM states, in frame order.
  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Bits per frame for the default configuration (start + 8 data + 1 stop).
  localparam int FRAME_BITS = 1 + 8 + 0 + 1;

endpackage

// File: rtl/fifo_uart_baud_cnt.sv
// Bit-period counter: counts 0..CLK_PER_BIT-1 and flags the last cycle of each bit.
module fifo_uart_baud_cnt #(
  parameter int CLK_PER_BIT = 16
) (
  input  logic                           rdClk,
  input  logic                           rst,
  input  logic                           clr,
  output logic [$clog2(CLK_PER_BIT)-1:0] cnt,
  output logic                           bitTick
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

  assign bitTick = (cnt == LAST);

  // Free-running within a bit period; held at zero outside the serial states.
  always_ff @(posedge rdClk) begin
    if (rst || clr)   cnt <= '0;
    else if (bitTick) cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer: pops bytes and serialises them as UART frames.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CLK_PER_BIT = 16,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0
) (
  input  logic              rdClk,
  input  logic              rst,
  input  logic              txEn,
  input  logic              fifoEmpty,
  input  logic [DATA_W-1:0] dout,
  output logic              rdEn,
  output logic              txd,
  output logic              busy,
  output logic              frameDone
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(CLK_PER_BIT - 2);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  if (CLK_PER_BIT < 2) begin : gBadClkPerBit
    $error("fifo_uart_tx: CLK_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : gBadStopBits
    $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
  end

  state_t            state, stateNext;
  logic [DATA_W-1:0] shReg, shNext;
  logic [BW-1:0]     bitCnt, bitCntNext;
  logic              parBit;
  logic              txdNext;
  logic [CW-1:0]     baudCnt;
  logic              bitTick;
  logic              baudClr;

  // Baud counter only runs while a bit is on the line.
  assign baudClr = (state == IDLE) || (state == POP) || (state == LOAD);

  fifo_uart_baud_cnt #(.CLK_PER_BIT(CLK_PER_BIT)) uBaud (
    .rdClk   (rdClk),
    .rst     (rst),
    .clr     (baudClr),
    .cnt     (baudCnt),
    .bitTick (bitTick)
  );

  // Next-state, shift register and bit counter; the bit counter is reused for stop bits.
  always_comb begin
    stateNext  = state;
    shNext     = shReg;
    bitCntNext = bitCnt;
    unique case (state)
      IDLE:   if (txEn && !fifoEmpty) stateNext = POP;
      POP:    stateNext = LOAD;
      LOAD: begin
        stateNext = START;
        shNext    = dout;
      end
      START:  if (bitTick) begin
        stateNext  = DATA;
        bitCntNext = '0;
      end
      DATA:   if (bitTick) begin
        shNext = shReg >> 1;
        if (bitCnt == LAST_DATA) begin
          bitCntNext = '0;
          stateNext  = (PARITY_EN != 0) ? PARITY : STOP;
        end else begin
          bitCntNext = bitCnt + 1'b1;
        end
      end
      PARITY: if (bitTick) begin
        stateNext  = STOP;
        bitCntNext = '0;
      end
      STOP:   if (bitTick) begin
        if (bitCnt == LAST_STOP) begin
          stateNext  = IDLE;
          bitCntNext = '0;
        end else begin
          bitCntNext = bitCnt + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Line level for the upcoming cycle, so txd lines up with the registered state.
  always_comb begin
    txdNext = 1'b1;
    case (stateNext)
      START:   txdNext = 1'b0;
      DATA:    txdNext = shNext[0];
      PARITY:  txdNext = parBit;
      default: txdNext = 1'b1;
    endcase
  end

  // FSM state and datapath registers; parity is taken from dout as it is captured.
  always_ff @(posedge rdClk) begin
    if (rst) begin
      state  <= IDLE;
      shReg  <= '0;
      bitCnt <= '0;
      parBit <= 1'b0;
    end else begin
      state  <= stateNext;
      shReg  <= shNext;
      bitCnt <= bitCntNext;
      if (state == LOAD) parBit <= (^dout) ^ 1'(PARITY_ODD);
    end
  end

  // Registered outputs; frameDone is raised one cycle early so it lands on the final stop cycle.
  always_ff @(posedge rdClk) begin
    if (rst) begin
      rdEn      <= 1'b0;
      txd       <= 1'b1;
      busy      <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      rdEn      <= (stateNext == POP);
      txd       <= txdNext;
      busy      <= (stateNext != IDLE);
      frameDone <= (state == STOP) && (bitCnt == LAST_STOP) && (baudCnt == PRE_LAST);
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: stimulus queues bytes and expected frames; per-instance monitors decode txd.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  typedef struct {
    logic [7:0] data;
    int         gap;    // expected start-to-start cycles, -1 = unchecked
    bit         bit9;   // expected bit after the data bits (parity, or stop if none)
    bit         abort;  // frame is expected to be cut by reset
  } exp_t;

  logic       rdClk = 1'b0;
  logic       rst   = 1'b1;
  logic [2:0] txEnV = 3'b000;
  logic [2:0] rdEnV, txdV, busyV;
  int         cyc = 0;
  int         mainCmp = 0, mainErr = 0;

  always #5 rdClk = ~rdClk;
  always @(posedge rdClk) cyc <= cyc + 1;

  // Instance 0: no parity; 1: even parity; 2: odd parity.
  for (genvar k = 0; k < 3; k++) begin : gI
    localparam int PE = (k != 0) ? 1 : 0;
    localparam int PO = (k == 2) ? 1 : 0;
    localparam int NB = 1 + 8 + PE + 1;
    localparam int NS = NB * CPB;

    logic       fifoEmpty = 1'b1;
    logic [7:0] dout = 8'h00;
    logic       frameDone;
    logic [7:0] fq[$];
    exp_t       expQ[$];
    int         nCmp = 0, nErr = 0, nRd = 0;
    bit         inFrame = 1'b0;
    int         sIdx = 0, startCyc = 0, prevStart = -1;
    bit         samp[NS];
    bit         fdv[NS];
    exp_t       e;
    logic [7:0] got;
    bit         shapeOk;
    int         fdCnt, fdPos;

    fifo_uart_tx #(
      .DATA_W(8), .CLK_PER_BIT(CPB), .STOP_BITS(1), .PARITY_EN(PE), .PARITY_ODD(PO)
    ) dut (
      .rdClk     (rdClk),
      .rst       (rst),
      .txEn      (txEnV[k]),
      .fifoEmpty (fifoEmpty),
      .dout      (dout),
      .rdEn      (rdEnV[k]),
      .txd       (txdV[k]),
      .busy      (busyV[k]),
      .frameDone (frameDone)
    );

    // FIFO model: data appears the cycle after rdEn is sampled.
    always @(posedge rdClk)
      if (rdEnV[k] === 1'b1 && fq.size() > 0) dout <= fq.pop_front();

    always @(negedge rdClk) fifoEmpty <= (fq.size() == 0);

    // Monitor: rdEn legality and frame decoding against the scoreboard.
    always @(negedge rdClk) begin
      if (rdEnV[k] === 1'b1) begin
        nRd++;
        nCmp++;
        if (fifoEmpty) begin
          nErr++;
          $display("FAIL rdEnWhileEmpty[%0d]: fifoEmpty=%b required 0", k, fifoEmpty);
        end
      end
      if (rst) begin
        if (inFrame) begin
          inFrame = 1'b0;
          nCmp++;
          if (expQ.size() == 0) begin
            nErr++;
            $display("FAIL abortNoExp[%0d]: no expected entry, required one", k);
          end else begin
            e = expQ.pop_front();
            if (!e.abort) begin
              nErr++;
              $display("FAIL abortFlag[%0d]: byte %h aborted, required full frame", k, e.data);
            end
          end
        end
      end else begin
        if (!inFrame && txdV[k] === 1'b0) begin
          inFrame  = 1'b1;
          sIdx     = 0;
          startCyc = cyc;
        end
        if (inFrame) begin
          samp[sIdx] = txdV[k];
          fdv[sIdx]  = frameDone;
          sIdx++;
          if (sIdx == NS) begin
            inFrame = 1'b0;
            shapeOk = 1'b1;
            for (int b = 0; b < NB; b++)
              for (int c = 1; c < CPB; c++)
                if (samp[b*CPB+c] != samp[b*CPB]) shapeOk = 1'b0;
            if (samp[0] != 1'b0 || samp[(NB-1)*CPB] != 1'b1) shapeOk = 1'b0;
            for (int j = 0; j < 8; j++) got[j] = samp[(1+j)*CPB];
            fdCnt = 0;
            fdPos = -1;
            for (int i = 0; i < NS; i++) if (fdv[i]) begin fdCnt++; fdPos = i + 1; end
            nCmp++;
            if (expQ.size() == 0) begin
              nErr++;
              $display("FAIL unexpFrame[%0d]: got byte %h, required no frame", k, got);
            end else begin
              e = expQ.pop_front();
              nCmp++;
              if (!shapeOk) begin
                nErr++;
                $display("FAIL frameShape[%0d]: shapeOk=%b required 1", k, shapeOk);
              end
              if (got != e.data) begin
                nErr++;
                $display("FAIL data[%0d]: got %h required %h", k, got, e.data);
              end
              nCmp++;
              if (samp[9*CPB] != e.bit9) begin
                nErr++;
                $display("FAIL bit9[%0d]: got %b required %b", k, samp[9*CPB], e.bit9);
              end
              nCmp++;
              if (fdCnt != 1 || fdPos != NS) begin
                nErr++;
                $display("FAIL frameDone[%0d]: pulses=%0d cycle=%0d required 1 at %0d", k, fdCnt, fdPos, NS);
              end
              if (e.gap >= 0) begin
                nCmp++;
                if (startCyc - prevStart != e.gap) begin
                  nErr++;
                  $display("FAIL gap[%0d]: got %0d required %0d", k, startCyc - prevStart, e.gap);
                end
              end
            end
            prevStart = startCyc;
          end
        end
      end
    end
  end

  task automatic push(input int k, input logic [7:0] d, input int gap, input bit b9, input bit ab);
    exp_t x;
    x.data = d; x.gap = gap; x.bit9 = b9; x.abort = ab;
    case (k)
      0: begin gI[0].fq.push_back(d); gI[0].expQ.push_back(x); end
      1: begin gI[1].fq.push_back(d); gI[1].expQ.push_back(x); end
      default: begin gI[2].fq.push_back(d); gI[2].expQ.push_back(x); end
    endcase
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return gI[0].expQ.size();
      1: return gI[1].expQ.size();
      default: return gI[2].expQ.size();
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    mainCmp++;
    if (act !== req) begin
      mainErr++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  // Wait until at most n frames are outstanding and the instance is idle.
  task automatic waitIdle(input int k, input int n, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge rdClk);
      if (qsize(k) <= n && busyV[k] == 1'b0) done = 1'b1;
    end
    mainCmp++;
    if (!done) begin
      mainErr++;
      $display("FAIL waitIdle[%0d]: timeout with %0d frames pending, required <= %0d", k, qsize(k), n);
    end
  endtask

  // Wait for the first START cycle of the next frame on instance 0.
  task automatic waitStart(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge rdClk);
      if (txdV[0] == 1'b0) done = 1'b1;
    end
    mainCmp++;
    if (!done) begin
      mainErr++;
      $display("FAIL waitStart: timeout, txd=%b required 0", txdV[0]);
    end
  endtask

  initial begin
    int tc, te;
    // Reset held 3 cycles with a byte waiting and txEn high.
    txEnV[0] = 1'b1;
    push(0, 8'hA5, -1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge rdClk); #1;
      chk("rstRdEn", {31'd0, rdEnV[0]}, 0);
      chk("rstTxd",  {31'd0, txdV[0]},  1);
      chk("rstBusy", {31'd0, busyV[0]}, 0);
    end
    rst = 1'b0;
    waitIdle(0, 0, 200);
    chk("rdCntSingle", gI[0].nRd, 1);

    // Three queued bytes, back to back.
    push(0, 8'h00, -1, 1'b1, 1'b0);
    push(0, 8'hFF, 43, 1'b1, 1'b0);
    push(0, 8'h3C, 43, 1'b1, 1'b0);
    waitIdle(0, 0, 400);
    repeat (10) @(negedge rdClk);
    chk("rdCntBurst", gI[0].nRd, 4);

    // txEn dropped during data bit 3: frame finishes, next byte waits.
    push(0, 8'h11, -1, 1'b1, 1'b0);
    push(0, 8'h22, -1, 1'b1, 1'b0);
    waitStart(200);
    repeat (18) @(negedge rdClk);
    txEnV[0] = 1'b0;
    waitIdle(0, 1, 200);
    repeat (20) @(negedge rdClk);
    chk("rdCntPaused", gI[0].nRd, 5);
    chk("busyPaused", {31'd0, busyV[0]}, 0);
    chk("txdPaused",  {31'd0, txdV[0]},  1);
    txEnV[0] = 1'b1;
    waitIdle(0, 0, 200);
    chk("rdCntResumed", gI[0].nRd, 6);

    // Reset during data bit 5: aborted byte is dropped, next byte follows.
    push(0, 8'h33, -1, 1'b1, 1'b1);
    push(0, 8'h44, -1, 1'b1, 1'b0);
    waitStart(200);
    repeat (26) @(negedge rdClk);
    @(posedge rdClk); #1;
    rst = 1'b1;
    @(posedge rdClk); #1;
    chk("abortTxd",  {31'd0, txdV[0]},  1);
    chk("abortBusy", {31'd0, busyV[0]}, 0);
    chk("abortRdEn", {31'd0, rdEnV[0]}, 0);
    rst = 1'b0;
    waitIdle(0, 0, 200);
    chk("rdCntAbort", gI[0].nRd, 8);

    // Parity on 8'h07 (three ones): even -> 1, odd -> 0; 44-cycle frames.
    push(1, 8'h07, -1, 1'b1, 1'b0);
    push(2, 8'h07, -1, 1'b0, 1'b0);
    txEnV[2:1] = 2'b11;
    waitIdle(1, 0, 200);
    waitIdle(2, 0, 200);
    chk("rdCntEven", gI[1].nRd, 1);
    chk("rdCntOdd",  gI[2].nRd, 1);

    repeat (5) @(negedge rdClk);
    tc = mainCmp + gI[0].nCmp + gI[1].nCmp + gI[2].nCmp;
    te = mainErr + gI[0].nErr + gI[1].nErr + gI[2].nErr;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", tc, te);
    $finish;
  end

endmodule
